// File: rtl/fetch_queue.sv
// fetch_queue: two-in / two-out instruction buffer between fetch and decode.
// Circular store of {pc, inst} entries with show-ahead read of the two oldest
// entries. Fetch pushes only when two slots are free, so a partial accept never
// happens. Decode consumes 0..2 entries per cycle, clamped to what is present.
module fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 push_valid,
    input  logic [PC_W-1:0]            push_pc0,
    input  logic [INST_W-1:0]          push_inst0,
    input  logic [PC_W-1:0]            push_pc1,
    input  logic [INST_W-1:0]          push_inst1,
    output logic                       push_ready,
    output logic [1:0]                 pop_valid,
    output logic [PC_W-1:0]            pop_pc0,
    output logic [INST_W-1:0]          pop_inst0,
    output logic [PC_W-1:0]            pop_pc1,
    output logic [INST_W-1:0]          pop_inst1,
    input  logic [1:0]                 pop_count,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_next1;
    logic [AW-1:0] tail_next1;

    logic [1:0] push_n;
    logic [1:0] pop_req;
    logic [1:0] pop_avail;
    logic [1:0] pop_n;

    // Neighbouring slots; power-of-two depth lets the pointer wrap by overflow.
    always_comb begin
        head_next1 = head + AW'(1);
        tail_next1 = tail + AW'(1);
    end

    // Ready depends only on registered occupancy, never on this cycle's pop.
    always_comb begin
        push_ready = (count <= CW'(DEPTH - 2));
    end

    // Number of entries written this cycle; lane1 alone is ignored.
    always_comb begin
        push_n = 2'd0;
        if (push_ready && push_valid[0]) begin
            push_n = push_valid[1] ? 2'd2 : 2'd1;
        end
    end

    // Effective pop: request saturates at two, then clamps to occupancy.
    always_comb begin
        pop_req = 2'd0;
        case (pop_count)
            2'd0:    pop_req = 2'd0;
            2'd1:    pop_req = 2'd1;
            default: pop_req = 2'd2;
        endcase
        pop_avail = 2'd0;
        if (count >= CW'(2)) begin
            pop_avail = 2'd2;
        end else if (count == CW'(1)) begin
            pop_avail = 2'd1;
        end
        pop_n = (pop_req < pop_avail) ? pop_req : pop_avail;
    end

    // Show-ahead outputs straight from storage; stale data when empty.
    always_comb begin
        pop_valid[0] = (count >= CW'(1));
        pop_valid[1] = (count >= CW'(2));
        pop_pc0      = pc_mem[head];
        pop_inst0    = inst_mem[head];
        pop_pc1      = pc_mem[head_next1];
        pop_inst1    = inst_mem[head_next1];
    end

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    // Entry writes; flushed pushes are dropped, flush leaves storage intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (!flush) begin
            if (push_n != 2'd0) begin
                pc_mem[tail]   <= push_pc0;
                inst_mem[tail] <= push_inst0;
            end
            if (push_n == 2'd2) begin
                pc_mem[tail_next1]   <= push_pc1;
                inst_mem[tail_next1] <= push_inst1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH  = 8;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [1:0]        push_valid;
    logic [PC_W-1:0]   push_pc0;
    logic [INST_W-1:0] push_inst0;
    logic [PC_W-1:0]   push_pc1;
    logic [INST_W-1:0] push_inst1;
    logic              push_ready;
    logic [1:0]        pop_valid;
    logic [PC_W-1:0]   pop_pc0;
    logic [INST_W-1:0] pop_inst0;
    logic [PC_W-1:0]   pop_pc1;
    logic [INST_W-1:0] pop_inst1;
    logic [1:0]        pop_count;
    logic [CW-1:0]     count;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_valid (push_valid),
        .push_pc0   (push_pc0),
        .push_inst0 (push_inst0),
        .push_pc1   (push_pc1),
        .push_inst1 (push_inst1),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_pc0    (pop_pc0),
        .pop_inst0  (pop_inst0),
        .pop_pc1    (pop_pc1),
        .pop_inst1  (pop_inst1),
        .pop_count  (pop_count),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [PC_W-1:0]   mq_pc[$];
    logic [INST_W-1:0] mq_inst[$];
    logic [PC_W-1:0]   next_pc;
    logic [PC_W-1:0]   pc_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output the model can predict.
    task automatic check_all(input string where);
        int n;
        n = mq_pc.size();
        chk({where, ":count"}, 64'(count), 64'(n));
        chk({where, ":pop_valid"}, 64'(pop_valid), 64'({n >= 2, n >= 1}));
        chk({where, ":push_ready"}, 64'(push_ready), 64'((DEPTH - n) >= 2));
        if (n >= 1) begin
            chk({where, ":pop_pc0"}, pop_pc0, mq_pc[0]);
            chk({where, ":pop_inst0"}, 64'(pop_inst0), 64'(mq_inst[0]));
        end
        if (n >= 2) begin
            chk({where, ":pop_pc1"}, pop_pc1, mq_pc[1]);
            chk({where, ":pop_inst1"}, 64'(pop_inst1), 64'(mq_inst[1]));
        end
    endtask

    // One clock: drive inputs, advance the model, sample at the next falling edge.
    task automatic cyc(input string where, input logic f, input logic [1:0] pv, input logic [1:0] pc_n);
        bit ready;
        int pops;
        flush      = f;
        push_valid = pv;
        pop_count  = pc_n;
        push_pc0   = next_pc;
        push_pc1   = next_pc + 64'd4;
        push_inst0 = $urandom;
        push_inst1 = $urandom;
        ready = (DEPTH - mq_pc.size()) >= 2;
        if (f) begin
            mq_pc.delete();
            mq_inst.delete();
        end else begin
            pops = (pc_n > 2) ? 2 : int'(pc_n);
            if (pops > mq_pc.size()) pops = mq_pc.size();
            for (int i = 0; i < pops; i++) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
            end
            if (ready && pv[0]) begin
                mq_pc.push_back(push_pc0);
                mq_inst.push_back(push_inst0);
                next_pc = next_pc + 64'd4;
                if (pv[1]) begin
                    mq_pc.push_back(push_pc1);
                    mq_inst.push_back(push_inst1);
                    next_pc = next_pc + 64'd4;
                end
            end
        end
        @(negedge clk);
        check_all(where);
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        push_valid = 2'b00;
        pop_count  = 2'd0;
        push_pc0   = '0;
        push_pc1   = '0;
        push_inst0 = '0;
        push_inst1 = '0;
        next_pc    = 64'h8000_0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst:count", 64'(count), 64'd0);
        chk("rst:pop_valid", 64'(pop_valid), 64'd0);
        chk("rst:push_ready", 64'(push_ready), 64'd1);
        chk("rst:pop_pc0", pop_pc0, 64'd0);
        chk("rst:pop_inst1", 64'(pop_inst1), 64'd0);

        // First two-lane push
        cyc("first", 1'b0, 2'b11, 2'd0);
        chk("first:pc0", pop_pc0, 64'h8000_0000);
        chk("first:pc1", pop_pc1, 64'h8000_0004);

        // Fill to full, then a dropped push at full
        cyc("fill4", 1'b0, 2'b11, 2'd0);
        cyc("fill6", 1'b0, 2'b11, 2'd0);
        chk("fill6:ready", 64'(push_ready), 64'd1);
        cyc("fill8", 1'b0, 2'b11, 2'd0);
        chk("fill8:count", 64'(count), 64'd8);
        pc_before = pop_pc0;
        cyc("drop", 1'b0, 2'b11, 2'd0);
        chk("drop:count", 64'(count), 64'd8);
        chk("drop:head", pop_pc0, pc_before);

        // Drain to 7: still not ready even while popping two
        cyc("to7", 1'b0, 2'b00, 2'd1);
        cyc("full7pop2", 1'b0, 2'b11, 2'd2);
        chk("full7:count", 64'(count), 64'd5);

        // Steady state push 2 / pop 2, pointers wrap
        for (int i = 0; i < 20; i++) begin
            pc_before = mq_pc[0];
            cyc("steady", 1'b0, 2'b11, 2'd2);
            chk("steady:seq", pop_pc0, pc_before + 64'd8);
        end

        // Stall with 3 entries, then single pop
        cyc("flush_a", 1'b1, 2'b00, 2'd0);
        cyc("stall_fill", 1'b0, 2'b11, 2'd0);
        cyc("stall_fill1", 1'b0, 2'b01, 2'd0);
        pc_before = mq_pc[0];
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 1'b0, 2'b00, 2'd0);
            chk("stall:hold", pop_pc0, pc_before);
        end
        cyc("stall_pop1", 1'b0, 2'b00, 2'd1);
        chk("stall:adv", pop_pc0, pc_before + 64'd4);

        // Over-pop from count 1, and lane1-only push ignored
        cyc("to1", 1'b0, 2'b00, 2'd1);
        cyc("overpop", 1'b0, 2'b10, 2'd3);
        chk("overpop:count", 64'(count), 64'd0);

        // Flush at count 5 with push and pop in the same cycle
        cyc("f5a", 1'b0, 2'b11, 2'd0);
        cyc("f5b", 1'b0, 2'b11, 2'd0);
        cyc("f5c", 1'b0, 2'b01, 2'd0);
        chk("f5:count", 64'(count), 64'd5);
        cyc("flush5", 1'b1, 2'b11, 2'd2);
        chk("flush5:count", 64'(count), 64'd0);
        chk("flush5:ready", 64'(push_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 31) == 0), 2'($urandom), 2'($urandom));
        end

        // Asynchronous reset mid-stream
        cyc("pre_rst", 1'b0, 2'b11, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst:count", 64'(count), 64'd0);
        chk("arst:pop_valid", 64'(pop_valid), 64'd0);
        chk("arst:pop_pc0", pop_pc0, 64'd0);
        chk("arst:pop_inst0", 64'(pop_inst0), 64'd0);
        mq_pc.delete();
        mq_inst.delete();
        @(negedge clk);
        reset = 1'b0;
        cyc("post_rst", 1'b0, 2'b11, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
